// File: rtl/calibration_pkg.sv
// Shared state encoding and helpers for the multi-channel calibration sequencer.
package calibration_pkg;

  localparam logic [7:0] CAL_ERROR_CODE = 8'hEE;
  localparam logic [7:0] SKIP_MAX       = 8'hFF;

  typedef enum logic [7:0] {
    ST_IDLE       = 8'h00,
    ST_ARM        = 8'h01,
    ST_WAIT_FG    = 8'h02,
    ST_DELAY      = 8'h03,
    ST_PULSE      = 8'h04,
    ST_WAIT_READY = 8'h05,
    ST_DONE       = 8'h06,
    ST_ERROR      = CAL_ERROR_CODE
  } cal_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == SKIP_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge pulse (one clock wide, STAGES+1 clocks after the input edge).
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_signal,
  input  logic async_in,
  output logic rise_pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  // STAGES must be at least 2 for the shift below to be meaningful.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/fsm_calibration_seq.sv
// Calibration burst sequencer: per frame-grabber edge, wait a delay, then fire a
// masked multi-channel trigger pulse; frames are gated on detector readiness.
module fsm_calibration_seq
  import calibration_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int COUNT_W       = 16,
  parameter int DELAY_W       = 32,
  parameter int PULSE_W       = 16,
  parameter int READY_TIMEOUT = 2_560_000
) (
  input  logic                clock,
  input  logic                reset_signal,
  input  logic                start_signal,
  input  logic                abort_signal,
  input  logic                fg_signal,
  input  logic                detector_ready,
  input  logic [COUNT_W-1:0]  frames_target,
  input  logic [DELAY_W-1:0]  delay_cycles,
  input  logic [PULSE_W-1:0]  pulse_cycles,
  input  logic [CHANNELS-1:0] channel_mask,
  output logic [CHANNELS-1:0] output_trigger,
  output logic [7:0]          scenario_state,
  output logic [COUNT_W-1:0]  counter_out,
  output logic [7:0]          skipped_out,
  output logic                busy,
  output logic                done
);

  localparam int              TO_W    = $clog2(READY_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(READY_TIMEOUT - 1);

  cal_state_t          state_q, state_d;
  logic                start_prev_q;
  logic                start_rise;
  logic                fg_rise;
  logic                load_cfg;
  logic                skip_hit;

  logic [COUNT_W-1:0]  target_q;
  logic [DELAY_W-1:0]  delay_q;
  logic [PULSE_W-1:0]  pulse_q;
  logic [CHANNELS-1:0] mask_q;

  logic [DELAY_W-1:0]  delay_cnt_q, delay_cnt_d;
  logic [PULSE_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [COUNT_W-1:0]  counter_q, counter_d, frame_next;
  logic [7:0]          skipped_q, skipped_d;
  logic [CHANNELS-1:0] trig_q, trig_d;

  sync_edge_detect #(.STAGES(2)) u_fg_sync (
    .clock        (clock),
    .reset_signal (reset_signal),
    .async_in     (fg_signal),
    .rise_pulse   (fg_rise)
  );

  assign start_rise = start_signal & ~start_prev_q;
  assign frame_next = counter_q + COUNT_W'(1);

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    skipped_d   = skipped_q;
    delay_cnt_d = delay_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    to_cnt_d    = to_cnt_q;
    load_cfg    = 1'b0;
    skip_hit    = 1'b0;

    if (abort_signal && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            load_cfg  = 1'b1;
            counter_d = '0;
            skipped_d = '0;
            // Degenerate configurations are resolved before arming.
            if (frames_target == '0)     state_d = ST_DONE;
            else if (channel_mask == '0) state_d = ST_ERROR;
            else                         state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          skip_hit = 1'b1;
          if (detector_ready) state_d = ST_WAIT_FG;
        end
        ST_WAIT_FG: begin
          if (fg_rise) begin
            pulse_cnt_d = pulse_q;
            if (delay_q == '0) begin
              state_d = ST_PULSE;
            end else begin
              delay_cnt_d = delay_q;
              state_d     = ST_DELAY;
            end
          end
        end
        ST_DELAY: begin
          skip_hit = 1'b1;
          if (delay_cnt_q == DELAY_W'(1)) state_d = ST_PULSE;
          else                            delay_cnt_d = delay_cnt_q - DELAY_W'(1);
        end
        ST_PULSE: begin
          skip_hit = 1'b1;
          if (pulse_cnt_q == PULSE_W'(1)) begin
            counter_d = frame_next;
            to_cnt_d  = '0;
            state_d   = (frame_next == target_q) ? ST_DONE : ST_WAIT_READY;
          end else begin
            pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
          end
        end
        ST_WAIT_READY: begin
          skip_hit = 1'b1;
          // Ready on the final timeout cycle still counts as ready.
          if (detector_ready)          state_d = ST_WAIT_FG;
          else if (to_cnt_q == TO_LAST) state_d = ST_ERROR;
          else                         to_cnt_d = to_cnt_q + TO_W'(1);
        end
        ST_DONE:  state_d = ST_IDLE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end

    if (skip_hit && fg_rise) skipped_d = sat_inc8(skipped_q);
  end

  always_comb begin
    trig_d = '0;
    if (state_d == ST_PULSE) trig_d = mask_q;
  end

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      counter_q    <= '0;
      skipped_q    <= '0;
      trig_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_signal;
      counter_q    <= counter_d;
      skipped_q    <= skipped_d;
      trig_q       <= trig_d;
    end
  end

  // Run configuration and timing counters are always loaded before use.
  always_ff @(posedge clock) begin
    if (load_cfg) begin
      target_q <= frames_target;
      delay_q  <= delay_cycles;
      pulse_q  <= (pulse_cycles == '0) ? PULSE_W'(1) : pulse_cycles;
      mask_q   <= channel_mask;
    end
    delay_cnt_q <= delay_cnt_d;
    pulse_cnt_q <= pulse_cnt_d;
    to_cnt_q    <= to_cnt_d;
  end

  assign output_trigger = trig_q;
  assign scenario_state = state_q;
  assign counter_out    = counter_q;
  assign skipped_out    = skipped_q;
  assign busy           = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign done           = (state_q == ST_DONE);

endmodule

// File: doc/fsm_calibration_seq.md
Name: fsm_calibration_seq

Overview:
- Parametrised successor to the single-channel calibration FSM.
- Runs a calibration burst of N frames. On each frame-grabber opto rising edge it waits a programmable delay, then fires a programmable-width trigger on a masked set of channels.
- Gates each subsequent frame on detector_ready, with a timeout.
- Sits between the frame-grabber opto input and the detector/illumination trigger outputs of the synchronisation block; exports state and progress counters for the host.

Parameters:
- CHANNELS, 4, number of trigger output channels (1..16)
- COUNT_W, 16, width of frame target and frame counter
- DELAY_W, 32, width of fg-to-trigger delay in clocks
- PULSE_W, 16, width of trigger pulse length in clocks
- READY_TIMEOUT, 2_560_000, max clocks in WAIT_READY before ERROR (12.8 ms at 200 MHz)

Ports:
- clock  in  1  system clock, 200 MHz
- reset_signal  in  1  asynchronous, active-low reset
- start_signal  in  1  run request; rising edge starts a run
- abort_signal  in  1  synchronous abort, level
- fg_signal  in  1  frame-grabber opto, asynchronous to clock
- detector_ready  in  1  detector ready for next exposure, synchronous
- frames_target  in  COUNT_W  frames per run
- delay_cycles  in  DELAY_W  clocks from fg edge to trigger
- pulse_cycles  in  PULSE_W  trigger high time in clocks
- channel_mask  in  CHANNELS  channels that fire
- output_trigger  out  CHANNELS  registered trigger outputs
- scenario_state  out  8  current state code
- counter_out  out  COUNT_W  frames completed in current/last run
- skipped_out  out  8  fg edges ignored outside WAIT_FG, saturating at 255
- busy  out  1  high in any state except IDLE and ERROR
- done  out  1  one-clock pulse at end of successful run

Behaviour:
- Reset (reset_signal low): state IDLE. All outputs 0: output_trigger, counter_out, skipped_out, busy, done, scenario_state=0x00.
- fg_signal path: 2-FF synchroniser plus rising-edge detect. fg_rise is a 1-clock pulse, 3 clocks after the input edge.
- Start: start_signal rising edge (registered compare) is honoured only in IDLE and ignored elsewhere. On start, the block latches frames_target, delay_cycles, pulse_cycles and channel_mask; config changes mid-run have no effect.
- State codes: IDLE 0x00, ARM 0x01, WAIT_FG 0x02, DELAY 0x03, PULSE 0x04, WAIT_READY 0x05, DONE 0x06, ERROR 0xEE.
- IDLE -> ARM on start.
  - Latched frames_target==0 -> DONE directly.
  - Latched mask==0 -> ERROR.
  - Both cases keep counter_out=0.
- ARM: clears counter_out and skipped_out; waits for detector_ready=1, then -> WAIT_FG.
- WAIT_FG: on fg_rise -> DELAY, or -> PULSE if delay==0.
- DELAY / PULSE timing:
  - The first trigger-high cycle is exactly D+1 clocks after the fg_rise cycle (D=latched delay).
  - output_trigger = latched mask for exactly P cycles; pulse_cycles==0 is treated as 1. It is 0 in every other state.
- End of PULSE: counter_out increments, visible the cycle after the last high cycle.
  - counter == target -> DONE.
  - Otherwise -> WAIT_READY.
- WAIT_READY: detector_ready=1 -> WAIT_FG. Timeout counter reaching READY_TIMEOUT -> ERROR. detector_ready sampled high on the same cycle as the timeout wins (go WAIT_FG).
- skipped_out: fg_rise in DELAY, PULSE, WAIT_READY or ARM increments it (saturating). fg_rise in IDLE, DONE or ERROR is not counted.
- DONE: done=1 for one clock, then IDLE. counter_out holds until the next start.
- ERROR: sticky; busy=0, triggers 0. Left only by abort_signal or reset.
- abort_signal=1 in any non-IDLE state -> IDLE on the next edge. Triggers drop at that edge; counter_out and skipped_out hold. Abort has priority over all other transitions, including fg_rise in the same cycle.
- Counter widths: delay and pulse counters are DELAY_W/PULSE_W wide, down-counting, with no wrap. The frame counter cannot exceed frames_target.

Decomposition:
- calibration_pkg holds:
  - typedef enum logic [7:0] cal_state_t with the codes above;
  - localparam CAL_ERROR_CODE = 8'hEE.
- One sub-module, sync_edge_detect: parameter STAGES=2, ports clock, reset_signal, async_in, rise_pulse. It is reused for the fg_signal path.

Test Plan:
- Basic run: target=3, delay=200, pulse=20, mask=4'b0101, detector_ready held 1, fg period 10 ms. Required: three pulses on channels 0 and 2 only, each 20 clocks wide, each rising 201 clocks after fg_rise (204 after the raw fg edge); counter_out 1,2,3; done pulse once; then IDLE.
- Zero delay/pulse: delay=0, pulse=0. Required: the trigger is high for exactly 1 clock, in the cycle after fg_rise.
- Ready gating: detector_ready low for 6.4 ms after each pulse, fg every 10 ms. Required: no missed frames. With fg every 2 ms instead, skipped_out counts the ignored edges and saturates at 255 over a long run.
- Timeout: target=2, detector_ready held low after the first pulse. Required: after READY_TIMEOUT clocks scenario_state=0xEE, busy=0, counter_out=1. abort_signal then returns the block to IDLE.
- Abort mid-pulse: assert abort on the 5th cycle of a 20-cycle pulse. Required: triggers low at the next edge, state 0x00, counter_out unchanged, no done.
- Reset and edge cases:
  - reset_signal low mid-DELAY: all outputs 0 asynchronously.
  - start held high across the end of a run: no restart.
  - target=0: done pulse with counter_out=0.
  - mask=0: ERROR.
